keyword_tx: RTL and testbench
=============================

KEYWORD_TX -- requirements
Module: keyword_tx

Interface
REQ-001 SHALL have parameter GAP_LEN, default 1, meaning filler characters inserted between keyword repetitions (0..15).
REQ-002 SHALL have parameter FILLER, default 8'h5F ("_"), meaning the ASCII code sent in each gap slot.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-006 SHALL have port reps  input  4  keyword repetitions; captured with start.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the burst in progress.
REQ-008 SHALL have port ascii  output  8  character on the stream.
REQ-009 SHALL have port valid  output  1  ascii is valid.
REQ-010 SHALL have port ready  input  1  sink accepts ascii this cycle.
REQ-011 SHALL have port busy  output  1  burst in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at normal burst end.

Function
REQ-013 SHALL transfer a character only on a cycle with valid=1 and ready=1 (beat).
REQ-014 SHALL hold ascii and valid stable while valid=1 and ready=0.
REQ-015 SHALL use FSM states IDLE, KEY, GAP, FIN.
REQ-016 IDLE: start=1 SHALL capture reps; reps>0 -> KEY, char index 0; reps=0 -> FIN.
REQ-017 SHALL present valid=1 with "B" in the cycle after start is sampled (one-cycle latency).
REQ-018 KEY SHALL send "B","O","M","B" in order, advancing the index only on a beat.
REQ-019 After the 4th keyword beat, SHALL decrement the remaining count: remaining>0 and GAP_LEN>0 -> GAP; remaining>0 and GAP_LEN=0 -> KEY, index 0; remaining=0 -> FIN.
REQ-020 GAP SHALL send FILLER exactly GAP_LEN beats, then return to KEY with index 0.
REQ-021 SHALL NOT send a gap after the final repetition.
REQ-022 FIN SHALL drive done=1 and valid=0 for one cycle, then enter IDLE.
REQ-023 busy SHALL be 1 in KEY, GAP and FIN, and 0 in IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with valid=0, busy=0, no done, even mid-stall; abort has priority over a beat in the same cycle.
REQ-026 start and abort both high in IDLE: abort SHALL win and the burst SHALL NOT start.
REQ-027 SHALL drive all outputs from registers; no combinational path from ready to valid.
REQ-028 SHALL use a 4-bit repetition counter and a 4-bit gap counter with no wrap-around; reps=15 yields 15 keywords.

Reset
REQ-029 rst=1 SHALL force IDLE, ascii=8'h00, valid=0, busy=0, done=0, all counters 0 on the next edge.
REQ-030 rst SHALL override start and abort; reset mid-burst SHALL discard the burst with no done.

Configuration
REQ-031 With KEYWORD_TX_PARITY_EN defined, SHALL add output ascii_par (1 bit) = XOR of ascii[7:0] (even parity), registered with ascii, reset 0, held stable with ascii under backpressure.
REQ-032 Without KEYWORD_TX_PARITY_EN, SHALL have no ascii_par port and no parity logic.

Structure
REQ-033 Package keyword_pkg SHALL hold KW_LEN=4, the keyword character constants "B","O","M","B", and the FSM state encoding.
REQ-034 No sub-module is required; keyword characters SHALL be indexed from the package constants.

Verification
REQ-035 reps=1, ready=1 constantly, start at cycle 0 -> beats "B","O","M","B" in cycles 1-4; done=1 in cycle 5; busy=0 from cycle 6.
REQ-036 reps=2, GAP_LEN=1, ready=1 -> stream "BOMB_BOMB" (9 beats); no trailing "_"; one done pulse.
REQ-037 reps=1, ready=0 for 3 cycles while "O" is presented -> "O" and valid held 3 cycles; sequence otherwise unchanged; done 3 cycles later than REQ-035.
REQ-038 reps=0 start -> valid never 1; done=1 in cycle 1.
REQ-039 reps=3, abort during second "M" with ready=0 -> valid=0 and busy=0 next cycle; no done; new start then works normally.
REQ-040 With KEYWORD_TX_PARITY_EN, reps=1 -> ascii_par 0,1,0,0 for "B"(42h),"O"(4Fh),"M"(4Dh),"B"(42h).

Source files
------------

// File: rtl/keyword_pkg.sv
// Shared constants for the keyword transmitter: keyword length, keyword characters, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package keyword_pkg;

    localparam int KW_LEN = 4;

    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CH_O = 8'h4F;
    localparam logic [7:0] CH_M = 8'h4D;

    // Element 0 is the first character on the wire.
    localparam logic [KW_LEN-1:0][7:0] KW_CHARS = {CH_B, CH_M, CH_O, CH_B};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Keyword character at a given index.
    function automatic logic [7:0] kw_char(input logic [1:0] idx);
        return KW_CHARS[idx];
    endfunction

endpackage

// File: rtl/keyword_tx.sv
// Streams "BOMB" reps times with GAP_LEN filler chars between repetitions; optional parity (KEYWORD_TX_PARITY_EN).
// Latency: first character valid one cycle after start is sampled; done pulses the cycle after the last beat.
// Backpressure: valid/ready; ascii and valid held stable while ready=0; all outputs registered.
module keyword_tx
    import keyword_pkg::*;
#(
    parameter int         GAP_LEN = 1,
    parameter logic [7:0] FILLER  = 8'h5F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] reps,
    input  logic       abort,
    output logic [7:0] ascii,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       done
`ifdef KEYWORD_TX_PARITY_EN
    ,
    output logic       ascii_par
`endif
);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] ascii_q, ascii_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       beat;
    logic [3:0] rem_dec;

    // Next-state and next-output logic; outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        ascii_d = ascii_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        beat    = valid_q & ready;
        rem_dec = rem_q - 4'd1;

        if (abort && state_q != IDLE) begin
            // Abort beats any pending transfer, including one accepted this very cycle.
            state_d = IDLE;
            idx_d   = 2'd0;
            rem_d   = 4'd0;
            gap_d   = 4'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        rem_d  = reps;
                        idx_d  = 2'd0;
                        busy_d = 1'b1;
                        if (reps != 4'd0) begin
                            state_d = KEY;
                            ascii_d = kw_char(2'd0);
                            valid_d = 1'b1;
                        end else begin
                            state_d = FIN;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                KEY: begin
                    if (beat) begin
                        if (idx_q == 2'(KW_LEN - 1)) begin
                            rem_d = rem_dec;
                            idx_d = 2'd0;
                            if (rem_dec == 4'd0) begin
                                // Last repetition: no trailing gap.
                                state_d = FIN;
                                valid_d = 1'b0;
                                done_d  = 1'b1;
                            end else if (GAP_LEN > 0) begin
                                state_d = GAP;
                                gap_d   = 4'(GAP_LEN);
                                ascii_d = FILLER;
                            end else begin
                                ascii_d = kw_char(2'd0);
                            end
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            ascii_d = kw_char(idx_q + 2'd1);
                        end
                    end
                end
                GAP: begin
                    if (beat) begin
                        gap_d = gap_q - 4'd1;
                        if (gap_q == 4'd1) begin
                            state_d = KEY;
                            idx_d   = 2'd0;
                            ascii_d = kw_char(2'd0);
                        end
                    end
                end
                FIN: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            rem_q   <= 4'd0;
            gap_q   <= 4'd0;
            ascii_q <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            ascii_q <= ascii_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ascii = ascii_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef KEYWORD_TX_PARITY_EN
    logic par_q;

    // Even parity registered alongside ascii so it holds with it under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^ascii_d;
        end
    end

    assign ascii_par = par_q;
`endif

endmodule

// File: tb/tb_keyword_tx.sv
// Self-checking bench for keyword_tx against a character-stream model.
// Latency: checks one-cycle start latency and done timing.
// Backpressure: random ready with hold-stability checks.
module tb_keyword_tx;

    localparam int         GAP_LEN = 1;
    localparam logic [7:0] FILLER  = 8'h5F;

    logic       clk = 1'b0;
    logic       rst, start, abort, ready;
    logic [3:0] reps;
    logic [7:0] ascii;
    logic       valid, busy, done;
`ifdef KEYWORD_TX_PARITY_EN
    logic       ascii_par;
`endif

    int errors = 0;
    int checks = 0;

    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    bit           par_q[$];

    keyword_tx #(.GAP_LEN(GAP_LEN), .FILLER(FILLER)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .reps  (reps),
        .abort (abort),
        .ascii (ascii),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .done  (done)
`ifdef KEYWORD_TX_PARITY_EN
        ,
        .ascii_par (ascii_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: reps copies of "BOMB", GAP_LEN fillers between consecutive copies only.
    task automatic build_expected(input int r);
        string kw;
        kw = "BOMB";
        exp_q.delete();
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back(kw[j]);
            if (i != r - 1)
                for (int g = 0; g < GAP_LEN; g++) exp_q.push_back(FILLER);
        end
    endtask

    function automatic string q2s(input byte unsigned q[$]);
        string s;
        s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    // Starts a burst and collects accepted characters until busy drops; checks hold under stall.
    task automatic run_burst(input logic [3:0] r, input int rdy_pct, input bit noise,
                             output int last_beat, output int done_cyc, output int n_done);
        bit          stalled;
        logic [7:0]  held;
        int          cyc;
        bit          finished;
        got_q.delete();
        par_q.delete();
        last_beat = -1; done_cyc = -1; n_done = 0;
        stalled = 0; held = 8'h00; finished = 0;
        start = 1; reps = r;
        tick();
        start = 0;
        cyc = 1;
        while (cyc < 400) begin
            if (stalled) begin
                checks++;
                if (valid !== 1'b1 || ascii !== held) begin
                    errors++;
                    $display("FAIL hold_stall cyc=%0d: valid=%b ascii=%h, required valid=1 ascii=%h", cyc, valid, ascii, held);
                end
            end
            if (done === 1'b1) begin n_done++; done_cyc = cyc; end
            if (busy !== 1'b1) begin finished = 1; break; end
            ready = ($urandom_range(99) < rdy_pct);
            start = noise && ($urandom_range(3) == 0);
            reps  = 4'($urandom_range(15));
            if (valid === 1'b1 && ready) begin
                got_q.push_back(ascii);
`ifdef KEYWORD_TX_PARITY_EN
                par_q.push_back(ascii_par);
`endif
                last_beat = cyc;
            end
            stalled = (valid === 1'b1) && !ready;
            held = ascii;
            tick();
            cyc++;
        end
        start = 0;
        ready = 1;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL burst_timeout: busy still %b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 1; abort = 1; ready = 1; reps = 4'd5;
        tick(); tick();
        checks++; if (ascii !== 8'h00) begin errors++; $display("FAIL reset_ascii: got %h, required 00", ascii); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
`ifdef KEYWORD_TX_PARITY_EN
        checks++; if (ascii_par !== 1'b0) begin errors++; $display("FAIL reset_par: got %b, required 0", ascii_par); end
`endif
        rst = 0; start = 0; abort = 0;
        tick();
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy, valid); end
    endtask

    // Cycle-exact single repetition, optionally stalling "O" for 3 cycles.
    task automatic test_single(input bit stall);
        string exp_chars;
        int    n, done_at;
        exp_chars = stall ? "BOOOOMB" : "BOMB";
        n = exp_chars.len();
        done_at = n + 1;
        ready = 1; reps = 4'd1; start = 1;
        tick(); start = 0;
        for (int c = 1; c <= done_at + 1; c++) begin
            if (c <= n) begin
                checks++;
                if (valid !== 1'b1 || ascii !== 8'(exp_chars[c-1]) || done !== 1'b0) begin
                    errors++;
                    $display("FAIL single_beat stall=%0d cyc=%0d: valid=%b ascii=%h done=%b, required 1 %h 0", stall, c, valid, ascii, done, exp_chars[c-1]);
                end
`ifdef KEYWORD_TX_PARITY_EN
                checks++;
                if (ascii_par !== ^exp_chars[c-1]) begin
                    errors++;
                    $display("FAIL parity cyc=%0d: got %b, required %b", c, ascii_par, ^exp_chars[c-1]);
                end
`endif
            end else if (c == done_at) begin
                checks++;
                if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_done stall=%0d cyc=%0d: done=%b valid=%b busy=%b, required 1 0 1", stall, c, done, valid, busy);
                end
            end else begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL single_idle stall=%0d cyc=%0d: busy=%b done=%b, required 0 0", stall, c, busy, done);
                end
            end
            ready = !(stall && c >= 2 && c <= 4);
            tick();
        end
        ready = 1;
    endtask

    task automatic test_gap();
        int lb, dc, nd;
        run_burst(4'd2, 100, 0, lb, dc, nd);
        build_expected(2);
        checks++;
        if (q2s(got_q) != "BOMB_BOMB") begin errors++; $display("FAIL gap_stream: got \"%s\", required \"BOMB_BOMB\"", q2s(got_q)); end
        checks++;
        if (nd != 1 || dc != lb + 1) begin errors++; $display("FAIL gap_done: pulses=%0d at %0d, required 1 at %0d", nd, dc, lb + 1); end
    endtask

    task automatic test_zero();
        bit saw_valid;
        saw_valid = 0;
        ready = 1; reps = 4'd0; start = 1;
        tick(); start = 0;
        checks++;
        if (done !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b valid=%b, required 1 0", done, valid); end
        for (int c = 0; c < 4; c++) begin
            if (valid === 1'b1) saw_valid = 1;
            tick();
        end
        checks++;
        if (saw_valid || busy !== 1'b0) begin errors++; $display("FAIL zero_quiet: saw_valid=%0d busy=%b, required 0 0", saw_valid, busy); end
    endtask

    // Abort at a given stream position with the given ready, then expect a quiet idle.
    task automatic abort_at(input logic [3:0] r, input int pos, input bit rdy, input string tag);
        int  beats;
        bit  saw_done;
        beats = 0; saw_done = 0;
        ready = 1; reps = r; start = 1;
        tick(); start = 0;
        for (int c = 0; c < 100 && beats < pos; c++) begin
            if (valid === 1'b1) beats++;
            tick();
        end
        ready = rdy; abort = 1;
        tick();
        abort = 0; ready = 1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b busy=%b done=%b, required 0 0 0", tag, valid, busy, done);
        end
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1 || valid === 1'b1) saw_done = 1;
            tick();
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL %s_quiet: activity after abort=1, required 0", tag); end
    endtask

    task automatic test_abort();
        int lb, dc, nd;
        abort_at(4'd3, 7, 1'b0, "abort_stall");
        abort_at(4'd2, 2, 1'b1, "abort_beat");
        run_burst(4'd1, 100, 0, lb, dc, nd);
        checks++;
        if (q2s(got_q) != "BOMB" || nd != 1) begin errors++; $display("FAIL abort_restart: got \"%s\" done=%0d, required \"BOMB\" 1", q2s(got_q), nd); end
        // start and abort together in IDLE: abort wins
        reps = 4'd1; start = 1; abort = 1;
        tick(); start = 0; abort = 0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL start_abort_idle: busy=%b valid=%b, required 0 0", busy, valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit act;
        act = 0;
        ready = 1; reps = 4'd3; start = 1;
        tick(); start = 0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1; start = 1; abort = 1;
        tick();
        rst = 0; start = 0; abort = 0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ascii !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b done=%b ascii=%h, required 0 0 0 00", valid, busy, done, ascii);
        end
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1 || valid === 1'b1) act = 1;
            tick();
        end
        checks++;
        if (act) begin errors++; $display("FAIL reset_mid_quiet: activity=1, required 0"); end
    endtask

    task automatic test_random();
        int lb, dc, nd, r;
        for (int t = 0; t < 25; t++) begin
            r = (t == 0) ? 15 : $urandom_range(15);
            run_burst(4'(r), 40 + $urandom_range(60), 1, lb, dc, nd);
            build_expected(r);
            checks++;
            if (q2s(got_q) != q2s(exp_q)) begin
                errors++;
                $display("FAIL rand_stream reps=%0d: got \"%s\", required \"%s\"", r, q2s(got_q), q2s(exp_q));
            end
            checks++;
            if (nd != 1 || dc != ((r == 0) ? 1 : lb + 1)) begin
                errors++;
                $display("FAIL rand_done reps=%0d: pulses=%0d at %0d, required 1 at %0d", r, nd, dc, (r == 0) ? 1 : lb + 1);
            end
`ifdef KEYWORD_TX_PARITY_EN
            foreach (par_q[i]) begin
                checks++;
                if (par_q[i] !== ^exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_par reps=%0d idx=%0d: got %b, required %b", r, i, par_q[i], ^exp_q[i]);
                end
            end
`endif
            tick();
        end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; ready = 1; reps = 4'd0;
        test_reset();
        test_single(0);
        test_single(1);
        test_gap();
        test_zero();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
